// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the single-port data memory
// between the core LSU (port 0) and the debug/loader port (port 1).
// Optional macro DMEM_ARB_LOCK_EN adds m1_lock exclusive access for port 1.
module dmem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              m1_lock,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic               rr_last;
  logic               lock_hold;
  logic [MEM_LAT-1:0] tag_vld;
  logic [MEM_LAT-1:0] tag_id;

`ifdef DMEM_ARB_LOCK_EN
  logic lock_active;

  // Lock is taken by a locked m1 grant and released once m1 drops m1_lock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_active <= 1'b0;
    end else if (m1_gnt && m1_lock) begin
      lock_active <= 1'b1;
    end else if (!m1_lock) begin
      lock_active <= 1'b0;
    end
  end

  assign lock_hold = lock_active;
`else
  assign lock_hold = 1'b0;
`endif

  // Grant: lone requester wins, a tie goes to the port not granted last
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!reset) begin
      if (lock_hold) begin
        m1_gnt = m1_req;
      end else if (m0_req && m1_req) begin
        m0_gnt = rr_last;
        m1_gnt = !rr_last;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  // Memory command muxed from the granted port
  always_comb begin
    mem_en    = m0_gnt | m1_gnt;
    mem_we    = m0_we;
    mem_addr  = m0_addr;
    mem_wdata = m0_wdata;
    mem_wstrb = m0_wstrb;
    if (m1_gnt) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_wstrb = m1_wstrb;
    end
  end

  // Remember the last granted port; reset value lets port 0 win the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last <= 1'b1;
    end else if (m0_gnt) begin
      rr_last <= 1'b0;
    end else if (m1_gnt) begin
      rr_last <= 1'b1;
    end
  end

  // Tag pipe tracks which port owns each in-flight read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= mem_en & ~mem_we;
      tag_id[0]  <= m1_gnt;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  assign m0_rvalid = tag_vld[MEM_LAT-1] & ~tag_id[MEM_LAT-1];
  assign m1_rvalid = tag_vld[MEM_LAT-1] &  tag_id[MEM_LAT-1];
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

`ifndef SYNTHESIS
  a_m0_hold: assert property (@(posedge clk) disable iff (reset)
    m0_req && !m0_gnt |=> m0_req && $stable(m0_addr) && $stable(m0_we));
  a_m1_hold: assert property (@(posedge clk) disable iff (reset)
    m1_req && !m1_gnt |=> m1_req && $stable(m1_addr) && $stable(m1_we));
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter
// Three DUTs (MEM_LAT 1..3) share stimulus; each has its own memory.
module tb_dmem_arbiter;

  localparam int NI = 3;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [9:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
`ifdef DMEM_ARB_LOCK_EN
  logic        m1_lock;
`endif

  logic        m0_gnt [NI];
  logic        m1_gnt [NI];
  logic        m0_rvalid [NI];
  logic        m1_rvalid [NI];
  logic [31:0] m0_rdata [NI];
  logic [31:0] m1_rdata [NI];
  logic        mem_en [NI];
  logic        mem_we [NI];
  logic [9:0]  mem_addr [NI];
  logic [31:0] mem_wdata [NI];
  logic [3:0]  mem_wstrb [NI];
  logic [31:0] mem_rdata [NI];

  logic [31:0] ref_mem [1024];
  exp_t        sb [NI][$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(int k);
    if (k == 5) return 32'h0000000E;
    if (k == 3) return 32'h0;
    return k * 32'h11;
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int LAT = gi + 1;
    logic [31:0] mem [1024];
    logic [31:0] dl [LAT];

    dmem_arbiter #(
      .ADDR_W (10),
      .DATA_W (32),
      .MEM_LAT(LAT)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .m0_req   (m0_req),
      .m0_we    (m0_we),
      .m0_addr  (m0_addr),
      .m0_wdata (m0_wdata),
      .m0_wstrb (m0_wstrb),
      .m0_gnt   (m0_gnt[gi]),
      .m0_rvalid(m0_rvalid[gi]),
      .m0_rdata (m0_rdata[gi]),
      .m1_req   (m1_req),
      .m1_we    (m1_we),
      .m1_addr  (m1_addr),
      .m1_wdata (m1_wdata),
      .m1_wstrb (m1_wstrb),
      .m1_gnt   (m1_gnt[gi]),
      .m1_rvalid(m1_rvalid[gi]),
      .m1_rdata (m1_rdata[gi]),
`ifdef DMEM_ARB_LOCK_EN
      .m1_lock  (m1_lock),
`endif
      .mem_en   (mem_en[gi]),
      .mem_we   (mem_we[gi]),
      .mem_addr (mem_addr[gi]),
      .mem_wdata(mem_wdata[gi]),
      .mem_wstrb(mem_wstrb[gi]),
      .mem_rdata(mem_rdata[gi])
    );

    initial for (int k = 0; k < 1024; k++) mem[k] = init_val(k);

    // single-port memory with LAT-cycle read pipe
    always @(posedge clk) begin
      if (mem_en[gi] && mem_we[gi])
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[gi][b])
            mem[mem_addr[gi]][8*b +: 8] <= mem_wdata[gi][8*b +: 8];
      dl[0] <= mem[mem_addr[gi]];
      for (int j = 1; j < LAT; j++) dl[j] <= dl[j-1];
    end

    assign mem_rdata[gi] = dl[LAT-1];

    // response monitor: pop and compare
    always @(negedge clk) begin
      exp_t e;
      if (!reset && (m0_rvalid[gi] || m1_rvalid[gi])) begin
        if (sb[gi].size() == 0) begin
          check($sformatf("L%0d_spurious_rvalid", LAT),
                {m1_rvalid[gi], m0_rvalid[gi]}, 0);
        end else begin
          e = sb[gi].pop_front();
          check($sformatf("L%0d_port", LAT),
                {m1_rvalid[gi], m0_rvalid[gi]},
                (e.port == 1) ? 2'b10 : 2'b01);
          check($sformatf("L%0d_rdata", LAT),
                m0_rvalid[gi] ? m0_rdata[gi] : m1_rdata[gi], e.data);
          check($sformatf("L%0d_idle_rdata", LAT),
                m0_rvalid[gi] ? m1_rdata[gi] : m0_rdata[gi], 0);
          check($sformatf("L%0d_latency", LAT), cyc, e.due);
        end
      end
    end
  end

  task automatic op(input int p, input bit we, input logic [9:0] a,
                    input logic [31:0] wd, input logic [3:0] ws,
                    output int gc);
    bit done = 1'b0;
    gc = -1;
    if (p == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = a;
      m0_wdata = wd; m0_wstrb = ws;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = a;
      m1_wdata = wd; m1_wstrb = ws;
    end
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if ((p == 0 && m0_gnt[0]) || (p == 1 && m1_gnt[0])) begin
        done = 1'b1;
        gc = cyc;
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (ws[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
        end else begin
          for (int i = 0; i < NI; i++)
            sb[i].push_back('{p, ref_mem[a], cyc + i + 1});
        end
      end
      @(posedge clk); #1;
    end
    if (p == 0) m0_req = 1'b0;
    else m1_req = 1'b0;
    if (!done) check($sformatf("p%0d_gnt_timeout", p), 0, 1);
  endtask

  task automatic rd(input int p, input logic [9:0] a, output int gc);
    op(p, 1'b0, a, 32'h0, 4'h0, gc);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < NI; i++) sb[i].delete();
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, g0a, g0b, g1a, g1b, gx;
    for (int k = 0; k < 1024; k++) ref_mem[k] = init_val(k);
    reset = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
`ifdef DMEM_ARB_LOCK_EN
    m1_lock = 1'b0;
`endif

    // reset state with requests pending
    @(negedge clk);
    check("reset_outputs", {m0_gnt[0], m1_gnt[0], mem_en[0],
          m0_rvalid[0], m1_rvalid[0]}, 0);
    check("reset_rdata", {m0_rdata[0], m1_rdata[0]}, 0);
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // single read, granted same cycle
    s = cyc;
    rd(0, 10'd5, g0a);
    check("t1_gnt_same_cycle", g0a, s);
    repeat (5) @(posedge clk); #1;

    // both request from reset: alternate grants
    do_reset(2);
    s = cyc;
    fork
      begin rd(0, 10'd1, g0a); rd(0, 10'd2, g0b); end
      begin rd(1, 10'd5, g1a); rd(1, 10'd6, g1b); end
      begin
        repeat (4) begin
          @(negedge clk);
          check("t2_mem_en", mem_en[0], 1'b1);
        end
      end
    join
    check("t2_g0a", g0a, s);
    check("t2_g1a", g1a, s + 1);
    check("t2_g0b", g0b, s + 2);
    check("t2_g1b", g1b, s + 3);
    repeat (5) @(posedge clk); #1;

    // masked write then read back
    op(1, 1'b1, 10'd3, 32'hDEADBEEF, 4'b0011, gx);
    rd(0, 10'd3, g0a);
    check("t3_ref_masked", ref_mem[3], 32'h0000BEEF);
    repeat (5) @(posedge clk); #1;

    // consecutive reads on different ports
    rd(0, 10'd1, g0a);
    rd(1, 10'd2, g1a);
    check("t4_consecutive", g1a, g0a + 1);
    repeat (5) @(posedge clk); #1;

    // reset one cycle after a read grant drops it
    rd(0, 10'd7, g0a);
    do_reset(1);
    repeat (6) @(posedge clk); #1;
    s = cyc;
    fork
      rd(0, 10'd8, g0a);
      rd(1, 10'd9, g1a);
    join
    check("t5_tie_m0", g0a, s);
    check("t5_tie_m1", g1a, s + 1);
    repeat (5) @(posedge clk); #1;

`ifdef DMEM_ARB_LOCK_EN
    // locked m1 burst holds off m0 until lock drops
    do_reset(2);
    s = cyc;
    fork
      begin
        m1_lock = 1'b1;
        rd(1, 10'd10, g1a);
        rd(1, 10'd11, g1b);
        rd(1, 10'd12, gx);
        m1_lock = 1'b0;
      end
      begin
        @(posedge clk); #1;
        rd(0, 10'd13, g0a);
      end
    join
    check("lk_m1_first", g1a, s);
    check("lk_m1_second", g1b, s + 1);
    check("lk_m1_third", gx, s + 2);
    check("lk_m0_after", g0a, s + 4);
    repeat (5) @(posedge clk); #1;
`endif

    // random contention with colliding addresses
    fork
      begin
        for (int n = 0; n < 12; n++)
          op(0, ($urandom_range(0, 9) < 3), 10'($urandom_range(0, 15)),
             $urandom, 4'($urandom_range(1, 15)), gx);
      end
      begin
        for (int n = 0; n < 12; n++)
          op(1, ($urandom_range(0, 9) < 3), 10'($urandom_range(0, 15)),
             $urandom, 4'($urandom_range(1, 15)), g1b);
      end
    join
    repeat (6) @(posedge clk); #1;

    for (int i = 0; i < NI; i++)
      check($sformatf("L%0d_sb_empty", i + 1), sb[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
